preset_release_sequencer: RTL and testbench

Generates the per-domain active-low preset lines that drive the iPreset inputs of downstream asynchronous-preset flip-flop groups. A raw external preset asserts every domain immediately and asynchronously. Deassertion is synchronized to iClock, then released one domain at a time with a programmable gap. Downstream preset flops therefore always see a clean, clock-aligned release edge, in a fixed order.

---
 rtl/preset_release_sequencer_pkg.sv | 14 +
 rtl/preset_release_sequencer_if.sv | 15 +
 rtl/preset_release_sequencer_sync_chain.sv | 20 ++
 rtl/preset_release_sequencer.sv | 63 ++++++
 tb/tb_preset_release_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/preset_release_sequencer_pkg.sv
// preset_release_sequencer_pkg: shared state encoding and default constants
// for the preset release sequencer.
package preset_release_sequencer_pkg;

    typedef enum logic [1:0] {
        PRESET = 2'd0,
        WAIT   = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int GAP_CYCLES_DEF  = 8;

endpackage

// File: rtl/preset_release_sequencer_if.sv
// preset_release_sequencer_if: soft-preset/hold controls in, sequenced
// per-domain preset lines and status out.
interface preset_release_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int IDX_W       = 3
);
    logic                   iSoftPreset;
    logic                   iHold;
    logic [NUM_DOMAINS-1:0] oPresetN;
    logic [IDX_W-1:0]       oReleased;
    logic                   oReady;

    modport master (output iSoftPreset, iHold, input oPresetN, oReleased, oReady);
    modport slave  (input iSoftPreset, iHold, output oPresetN, oReleased, oReady);
endinterface

// File: rtl/preset_release_sequencer_sync_chain.sv
// preset_sync_chain: asserts asynchronously with iPreset, deasserts after
// SYNC_STAGES iClock edges so the release is clock-aligned.
module preset_sync_chain
    import preset_release_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic iClock,
    input  logic iPreset,
    output logic release_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge iClock or negedge iPreset) begin
        if (!iPreset) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign release_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/preset_release_sequencer.sv
// preset_release_sequencer: releases per-domain active-low presets one at a
// time, GAP_CYCLES apart, after a synchronized deassertion of iPreset.
module preset_release_sequencer
    import preset_release_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 3
) (
    input  logic                      iClock,
    input  logic                      iPreset,
    preset_release_sequencer_if.slave bus
);
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_DOMAINS-1:0] preset_n_q;
    logic [IDX_W-1:0]       released_q;
    logic                   ready_q;
    logic                   sync_release;

    preset_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .iClock    (iClock),
        .iPreset   (iPreset),
        .release_o (sync_release)
    );

    always_ff @(posedge iClock or negedge iPreset) begin
        if (!iPreset) begin
            state_q    <= PRESET;
            cnt_q      <= '0;
            preset_n_q <= '0;
            released_q <= '0;
            ready_q    <= 1'b0;
        end else if (state_q == PRESET) begin
            if (sync_release) state_q <= WAIT;
        end else if (bus.iSoftPreset) begin
            state_q    <= WAIT;
            cnt_q      <= '0;
            preset_n_q <= '0;
            released_q <= '0;
            ready_q    <= 1'b0;
        end else if (state_q == WAIT && !bus.iHold) begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                // released_q doubles as the index of the next domain to free
                preset_n_q <= preset_n_q | (NUM_DOMAINS'(1) << released_q);
                released_q <= released_q + 1'b1;
                cnt_q      <= '0;
                if (released_q == IDX_W'(NUM_DOMAINS - 1)) begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.oPresetN  = preset_n_q;
    assign bus.oReleased = released_q;
    assign bus.oReady    = ready_q;
endmodule

// File: tb/tb_preset_release_sequencer.sv
// tb_preset_release_sequencer: directed scenarios for the default build and a
// single-domain / gap-1 / three-stage build, checked against hand-derived values.
module tb_preset_release_sequencer;
    logic iClock    = 1'b0;
    logic iPreset   = 1'b0;
    int   total     = 0;
    int   bad       = 0;
    logic [7:0] got;
    logic [4:0] got_b;

    preset_release_sequencer_if #(.NUM_DOMAINS(4), .IDX_W(3)) bus ();
    preset_release_sequencer_if #(.NUM_DOMAINS(1), .IDX_W(3)) bus_b ();

    preset_release_sequencer dut (
        .iClock  (iClock),
        .iPreset (iPreset),
        .bus     (bus)
    );

    preset_release_sequencer #(
        .SYNC_STAGES(3), .NUM_DOMAINS(1), .GAP_CYCLES(1), .CNT_W(8), .IDX_W(3)
    ) dut_b (
        .iClock  (iClock),
        .iPreset (iPreset),
        .bus     (bus_b)
    );

    always #5 iClock = ~iClock;

    assign got   = {bus.oPresetN, bus.oReleased, bus.oReady};
    assign got_b = {bus_b.oPresetN, bus_b.oReleased, bus_b.oReady};

    task automatic tick(input int n);
        repeat (n) @(posedge iClock);
        #1;
    endtask

    // Leaves iPreset rising mid-cycle so the next rising edge is E1.
    task automatic restart();
        @(negedge iClock);
        iPreset = 1'b0;
        repeat (5) @(negedge iClock);
        iPreset = 1'b1;
    endtask

    task automatic test_reset();
        tick(3);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL reset got=%h want=%h", got, 8'h00);
        end
        total++;
        if (got_b !== 5'b0_000_0) begin
            bad++;
            $display("FAIL reset_b got=%b want=%b", got_b, 5'b0_000_0);
        end
    endtask

    task automatic test_powerup();
        int         ed [9] = '{10, 11, 18, 19, 26, 27, 34, 35, 45};
        logic [7:0] ex [9] = '{8'h00, 8'h12, 8'h12, 8'h34, 8'h34, 8'h76, 8'h76, 8'hF9, 8'hF9};
        int cur;
        restart();
        bus.iSoftPreset = 1'b1;
        tick(3);
        bus.iSoftPreset = 1'b0;
        cur = 3;
        for (int i = 0; i < 9; i++) begin
            tick(ed[i] - cur);
            cur = ed[i];
            total++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL powerup@E%0d got=%h want=%h", ed[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_async_assert();
        restart();
        tick(23);
        total++;
        if (got !== 8'h34) begin
            bad++;
            $display("FAIL async_pre@E23 got=%h want=%h", got, 8'h34);
        end
        @(negedge iClock);
        iPreset = 1'b0;
        #1;
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL async_clear got=%h want=%h", got, 8'h00);
        end
        @(negedge iClock);
        iPreset = 1'b1;
        tick(10);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL async_restart@E10 got=%h want=%h", got, 8'h00);
        end
        tick(1);
        total++;
        if (got !== 8'h12) begin
            bad++;
            $display("FAIL async_restart@E11 got=%h want=%h", got, 8'h12);
        end
    endtask

    task automatic test_soft_done();
        int         ed [6] = '{47, 48, 56, 64, 71, 72};
        logic [7:0] ex [6] = '{8'h00, 8'h12, 8'h34, 8'h76, 8'h76, 8'hF9};
        int cur;
        restart();
        tick(39);
        total++;
        if (got !== 8'hF9) begin
            bad++;
            $display("FAIL soft_done_pre@E39 got=%h want=%h", got, 8'hF9);
        end
        bus.iSoftPreset = 1'b1;
        tick(1);
        bus.iSoftPreset = 1'b0;
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL soft_done@E40 got=%h want=%h", got, 8'h00);
        end
        cur = 40;
        for (int i = 0; i < 6; i++) begin
            tick(ed[i] - cur);
            cur = ed[i];
            total++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL soft_done@E%0d got=%h want=%h", ed[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_hold();
        int         ed [7] = '{19, 23, 24, 31, 32, 39, 40};
        logic [7:0] ex [7] = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h76, 8'h76, 8'hF9};
        int cur;
        restart();
        tick(14);
        bus.iHold = 1'b1;
        cur = 14;
        for (int i = 0; i < 7; i++) begin
            tick(ed[i] - cur);
            cur = ed[i];
            if (cur == 19) bus.iHold = 1'b0;
            total++;
            if (got !== ex[i]) begin
                bad++;
                $display("FAIL hold@E%0d got=%h want=%h", ed[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_priority();
        restart();
        tick(19);
        bus.iSoftPreset = 1'b1;
        bus.iHold       = 1'b1;
        tick(1);
        bus.iSoftPreset = 1'b0;
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL prio@E20 got=%h want=%h", got, 8'h00);
        end
        tick(5);
        bus.iHold = 1'b0;
        tick(7);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL prio@E32 got=%h want=%h", got, 8'h00);
        end
        tick(1);
        total++;
        if (got !== 8'h12) begin
            bad++;
            $display("FAIL prio@E33 got=%h want=%h", got, 8'h12);
        end
        bus.iSoftPreset = 1'b1;
        tick(12);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL soft_held got=%h want=%h", got, 8'h00);
        end
        bus.iSoftPreset = 1'b0;
        tick(7);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL soft_held_after7 got=%h want=%h", got, 8'h00);
        end
        tick(1);
        total++;
        if (got !== 8'h12) begin
            bad++;
            $display("FAIL soft_held_after8 got=%h want=%h", got, 8'h12);
        end
    endtask

    task automatic test_sweep();
        restart();
        tick(4);
        total++;
        if (got_b !== 5'b0_000_0) begin
            bad++;
            $display("FAIL sweep@E4 got=%b want=%b", got_b, 5'b0_000_0);
        end
        tick(1);
        total++;
        if (got_b !== 5'b1_001_1) begin
            bad++;
            $display("FAIL sweep@E5 got=%b want=%b", got_b, 5'b1_001_1);
        end
        tick(5);
        total++;
        if (got_b !== 5'b1_001_1) begin
            bad++;
            $display("FAIL sweep@E10 got=%b want=%b", got_b, 5'b1_001_1);
        end
    endtask

    initial begin
        bus.iSoftPreset   = 1'b0;
        bus.iHold         = 1'b0;
        bus_b.iSoftPreset = 1'b0;
        bus_b.iHold       = 1'b0;
        test_reset();
        test_powerup();
        test_async_assert();
        test_soft_done();
        test_hold();
        test_priority();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
